// File: rtl/softmax_normalize.sv
`default_nettype none
// ============================================================================
// Module      : softmax_normalize
// Description : Final softmax stage. Collects a vector of exponential-stage
//               samples (signed Q3.5, negatives clamp to zero), sums them,
//               computes R = floor(2^20 / sum) with a restoring divider, then
//               streams out each sample scaled as min(255, (x * R) >> 12)
//               as an unsigned Q0.8 probability.
// Ports       : clk, rst_n (async, active-low)
//               in_valid/in_ready/in_data/in_last   - sample input stream
//               out_valid/out_ready/out_data/out_last - probability stream
//               busy - high while dividing or emitting
// Revision    : 1.0 - initial release
// ============================================================================
module softmax_normalize #(
    parameter int XY_SZ = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XY_SZ-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XY_SZ-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;
    localparam int c_SUM_W  = 12;
    localparam int c_R_W    = 21;
    localparam int c_REM_W  = c_SUM_W + 1;
    localparam int c_PROD_W = XY_SZ + c_R_W;
    localparam int c_SHIFT  = 12;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DIVIDE  = 2'd1,
        EMIT    = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   r_idx;
    logic [c_SUM_W-1:0]   r_sum;
    logic [c_REM_W-1:0]   r_rem;
    logic [c_R_W-1:0]     r_recip;
    logic [4:0]           r_step;
    logic [XY_SZ-1:0]     r_buf [DEPTH];
    logic                 r_out_valid;
    logic                 r_out_last;
    logic [XY_SZ-1:0]     r_out_data;

    logic                 w_accept;
    logic                 w_vec_end;
    logic [XY_SZ-1:0]     w_sample;
    logic [c_REM_W:0]     w_rem_shift;
    logic                 w_rem_ge;
    logic [XY_SZ-1:0]     w_elem;
    logic [c_PROD_W-1:0]  w_prod;
    logic [c_PROD_W-1:0]  w_scaled;
    logic [XY_SZ-1:0]     w_sat;
    logic                 w_is_last_elem;

    assign in_ready  = (r_state == COLLECT);
    assign busy      = (r_state != COLLECT);
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;

    assign w_accept  = in_valid && (r_state == COLLECT);
    // A full buffer closes the vector even without in_last.
    assign w_vec_end = in_last || (r_count == c_CNT_W'(DEPTH - 1));
    // Negative exponential results are treated as zero weight.
    assign w_sample  = in_data[XY_SZ-1] ? '0 : in_data;

    // Restoring division of 2^20: the dividend has a single 1 at its MSB, so
    // the bit shifted in is 1 only on the first step.
    assign w_rem_shift = {r_rem, (r_step == 5'd0)};
    assign w_rem_ge    = (w_rem_shift >= (c_REM_W + 1)'(r_sum));

    assign w_elem         = r_buf[r_idx[c_ADDR_W-1:0]];
    assign w_prod         = c_PROD_W'(w_elem) * c_PROD_W'(r_recip);
    assign w_scaled       = w_prod >> c_SHIFT;
    assign w_sat          = (|w_scaled[c_PROD_W-1:XY_SZ]) ? '1 : w_scaled[XY_SZ-1:0];
    assign w_is_last_elem = (r_idx == r_count - c_CNT_W'(1));

    // Sample storage carries no reset; it is only read after being written.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_count[c_ADDR_W-1:0]] <= w_sample;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= COLLECT;
            r_count     <= '0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_rem       <= '0;
            r_recip     <= '0;
            r_step      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        r_sum   <= r_sum + c_SUM_W'(w_sample);
                        r_count <= r_count + c_CNT_W'(1);
                        if (w_vec_end) begin
                            r_state <= DIVIDE;
                            r_step  <= '0;
                            r_rem   <= '0;
                            r_recip <= '0;
                        end
                    end
                end

                DIVIDE: begin
                    r_rem   <= c_REM_W'(w_rem_ge ? (w_rem_shift - (c_REM_W + 1)'(r_sum))
                                                 : w_rem_shift);
                    r_recip <= {r_recip[c_R_W-2:0], w_rem_ge};
                    r_step  <= r_step + 5'd1;
                    if (r_step == 5'd20) begin
                        r_state <= EMIT;
                        r_idx   <= '0;
                        // Dividing by zero yields all ones; the vector is all
                        // zero weight, so force a zero reciprocal instead.
                        if (r_sum == '0) begin
                            r_recip <= '0;
                        end
                    end
                end

                EMIT: begin
                    // Load a new element when nothing is presented yet or the
                    // presented one is being taken this cycle.
                    if (!r_out_valid || out_ready) begin
                        if (r_out_valid && r_out_last) begin
                            r_state     <= COLLECT;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_data  <= '0;
                            r_count     <= '0;
                            r_sum       <= '0;
                        end else begin
                            r_out_data  <= w_sat;
                            r_out_last  <= w_is_last_elem;
                            r_out_valid <= 1'b1;
                            r_idx       <= r_idx + c_CNT_W'(1);
                        end
                    end
                end

                default: begin
                    r_state <= COLLECT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_softmax_normalize.sv
`default_nettype none
// ============================================================================
// Module      : tb_softmax_normalize
// Description : Directed self-checking bench for softmax_normalize. Expected
//               outputs are hand-computed from min(255, (x * R) >> 12) with
//               R = floor(2^20 / sum).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_softmax_normalize;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int checks;
    int errors;

    softmax_normalize #(
        .XY_SZ(8),
        .DEPTH(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers start and end on a falling edge; they do no checking.
    task automatic send(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic get_output(output logic [7:0] d, output logic l, output bit ok);
        ok = 1'b0;
        d  = 8'h00;
        l  = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (out_valid === 1'b1) begin
                d  = out_data;
                l  = out_last;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_last, out_data, busy, in_ready} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got valid=%b last=%b data=%h busy=%b ready=%b, expected 0 0 00 0 1",
                     out_valid, out_last, out_data, busy, in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [7:0] d;
        logic       l;
        bit         ok;
        send(8'h20, 1'b1);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: got busy=%b ready=%b, expected 1 0", busy, in_ready);
        end
        repeat (21) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early_valid: got out_valid=%b after E+21, expected 0", out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: got out_valid=%b after E+22, expected 1", out_valid);
        end
        get_output(d, l, ok);
        checks++;
        if (!ok || d !== 8'hFF || l !== 1'b1) begin
            errors++;
            $display("FAIL single_out: got ok=%b data=%h last=%b, expected data=ff last=1", ok, d, l);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_return: got valid=%b ready=%b busy=%b, expected 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_four();
        logic [7:0] d;
        logic       l;
        bit         ok;
        for (int i = 0; i < 4; i++) send(8'h20, i == 3);
        for (int i = 0; i < 4; i++) begin
            get_output(d, l, ok);
            checks++;
            if (!ok || d !== 8'h40 || l !== (i == 3)) begin
                errors++;
                $display("FAIL four_out[%0d]: got ok=%b data=%h last=%b, expected data=40 last=%b",
                         i, ok, d, l, i == 3);
            end
        end
    endtask

    task automatic test_depth();
        logic [7:0] d;
        logic       l;
        bit         ok;
        for (int i = 0; i < 16; i++) send(8'h10, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL depth_close: got ready=%b busy=%b, expected 0 1", in_ready, busy);
        end
        for (int i = 0; i < 16; i++) begin
            get_output(d, l, ok);
            checks++;
            if (!ok || d !== 8'h10 || l !== (i == 15)) begin
                errors++;
                $display("FAIL depth_out[%0d]: got ok=%b data=%h last=%b, expected data=10 last=%b",
                         i, ok, d, l, i == 15);
            end
        end
    endtask

    task automatic test_zero();
        logic [7:0] d;
        logic       l;
        bit         ok;
        send(8'h00, 1'b0);
        send(8'h80, 1'b0);
        send(8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            get_output(d, l, ok);
            checks++;
            if (!ok || d !== 8'h00 || l !== (i == 2)) begin
                errors++;
                $display("FAIL zero_out[%0d]: got ok=%b data=%h last=%b, expected data=00 last=%b",
                         i, ok, d, l, i == 2);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] d;
        logic       l;
        bit         ok;
        bit         seen;
        out_ready = 1'b0;
        send(8'h20, 1'b0);
        send(8'h60, 1'b1);
        // Extra samples offered while dividing must be dropped.
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            in_valid = (k % 3) == 0;
            in_data  = 8'h7F;
            in_last  = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_first_valid: got no out_valid within bound, expected 1");
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            in_data  = 8'h7F;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h40 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h last=%b, expected 1 40 0",
                         k, out_valid, out_data, out_last);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        get_output(d, l, ok);
        checks++;
        if (!ok || d !== 8'h40 || l !== 1'b0) begin
            errors++;
            $display("FAIL bp_out0: got ok=%b data=%h last=%b, expected data=40 last=0", ok, d, l);
        end
        get_output(d, l, ok);
        checks++;
        if (!ok || d !== 8'hC0 || l !== 1'b1) begin
            errors++;
            $display("FAIL bp_out1: got ok=%b data=%h last=%b, expected data=c0 last=1", ok, d, l);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_return: got valid=%b ready=%b, expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_emit();
        logic [7:0] d;
        logic       l;
        bit         ok;
        bit         stray;
        for (int i = 0; i < 4; i++) send(8'h20, i == 3);
        get_output(d, l, ok);
        checks++;
        if (!ok || d !== 8'h40 || l !== 1'b0) begin
            errors++;
            $display("FAIL rst_first: got ok=%b data=%h last=%b, expected data=40 last=0", ok, d, l);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_last, out_data, busy, in_ready} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rst_async: got valid=%b last=%b data=%h busy=%b ready=%b, expected 0 0 00 0 1",
                     out_valid, out_last, out_data, busy, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h20, 1'b1);
        get_output(d, l, ok);
        checks++;
        if (!ok || d !== 8'hFF || l !== 1'b1) begin
            errors++;
            $display("FAIL rst_after: got ok=%b data=%h last=%b, expected data=ff last=1", ok, d, l);
        end
        stray = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (out_valid !== 1'b0) stray = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL rst_no_residue: got stray out_valid after vector, expected none");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_four();
        test_depth();
        test_zero();
        test_backpressure();
        test_reset_mid_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
